// File: rtl/debug_pkg.sv
// Shared constants and FSM state encoding for the debug register dump path.
// DEBUG_DUMP_PC_EN adds a trailing program-counter word to the dump.
package debug_pkg;

    localparam int DEFAULT_DATA_SIZE = 32;
    localparam int DEFAULT_BYTE_SIZE = 8;
    localparam int DEFAULT_REG_SIZE  = 5;
    localparam int DEFAULT_NUM_REGS  = 32;
    localparam int BYTES_PER_WORD    = DEFAULT_DATA_SIZE / DEFAULT_BYTE_SIZE;

    // Total bytes the debug unit should expect on the UART for one dump.
`ifdef DEBUG_DUMP_PC_EN
    localparam int DUMP_BYTE_COUNT = (DEFAULT_NUM_REGS + 1) * BYTES_PER_WORD;
`else
    localparam int DUMP_BYTE_COUNT = DEFAULT_NUM_REGS * BYTES_PER_WORD;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5,
        ST_PC_LOAD = 3'd6
    } dump_state_t;

endpackage

// File: rtl/word_serializer.sv
// Loads one word and emits it MSB byte first over a valid/ready byte stream;
// flags the handshake of the final byte so the caller can move on.
module word_serializer
    import debug_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_SIZE-1:0] word,
    input  logic                 send,
    input  logic                 ready,
    output logic                 valid,
    output logic [BYTE_SIZE-1:0] data,
    output logic                 last_accept
);

    localparam int WORD_BYTES = DATA_SIZE / BYTE_SIZE;
    localparam int CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [DATA_SIZE-1:0] shift;
    logic [CNT_W-1:0]     count;
    logic                 accept;

    assign valid       = send;
    assign data        = shift[DATA_SIZE-1 -: BYTE_SIZE];
    assign accept      = send && ready;
    assign last_accept = accept && (count == CNT_W'(WORD_BYTES - 1));

    // Shift only on an accepted byte so the presented byte holds while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift <= '0;
            count <= '0;
        end else if (load) begin
            shift <= word;
            count <= '0;
        end else if (accept) begin
            shift <= shift << BYTE_SIZE;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_reg_dump.sv
// Walks the register bank debug port and streams every word MSB byte first.
// Build with DEBUG_DUMP_PC_EN to append the i_pc word after the last register.
module debug_reg_dump
    import debug_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int REG_SIZE  = DEFAULT_REG_SIZE,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [DATA_SIZE-1:0] i_rb_data,
    input  logic                 i_tx_ready,
`ifdef DEBUG_DUMP_PC_EN
    input  logic [DATA_SIZE-1:0] i_pc,
`endif
    output logic                 o_rb_read_enable,
    output logic [REG_SIZE-1:0]  o_rb_read_addr,
    output logic                 o_tx_valid,
    output logic [BYTE_SIZE-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [REG_SIZE-1:0] LAST_INDEX = REG_SIZE'(NUM_REGS - 1);

    dump_state_t          state;
    dump_state_t          next_state;
    logic [REG_SIZE-1:0]  index;
    logic                 ser_load;
    logic [DATA_SIZE-1:0] ser_word;
    logic                 last_accept;

`ifdef DEBUG_DUMP_PC_EN
    logic pc_phase;

    assign ser_load = (state == ST_WAIT) || (state == ST_PC_LOAD);
    assign ser_word = (state == ST_PC_LOAD) ? i_pc : i_rb_data;

    // Remembers that the word now being sent is the PC, which ends the dump.
    always_ff @(posedge i_clock) begin
        if (i_reset || state == ST_IDLE) begin
            pc_phase <= 1'b0;
        end else if (state == ST_PC_LOAD) begin
            pc_phase <= 1'b1;
        end
    end
`else
    assign ser_load = (state == ST_WAIT);
    assign ser_word = i_rb_data;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
            index <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && i_start) begin
                index <= '0;
            end else if (state == ST_NEXT && index != LAST_INDEX) begin
                index <= index + REG_SIZE'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (i_start) next_state = ST_REQ;
            ST_REQ:  next_state = ST_WAIT;
            ST_WAIT: next_state = ST_SEND;
            ST_SEND: begin
                if (last_accept) begin
`ifdef DEBUG_DUMP_PC_EN
                    next_state = pc_phase ? ST_DONE : ST_NEXT;
`else
                    next_state = ST_NEXT;
`endif
                end
            end
            ST_NEXT: begin
                if (index == LAST_INDEX) begin
`ifdef DEBUG_DUMP_PC_EN
                    next_state = ST_PC_LOAD;
`else
                    next_state = ST_DONE;
`endif
                end else begin
                    next_state = ST_REQ;
                end
            end
            ST_PC_LOAD: next_state = ST_SEND;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign o_rb_read_enable = (state == ST_REQ);
    assign o_rb_read_addr   = (state == ST_IDLE) ? '0 : index;
    assign o_busy           = (state != ST_IDLE);
    assign o_done           = (state == ST_DONE);

    word_serializer #(
        .DATA_SIZE(DATA_SIZE),
        .BYTE_SIZE(BYTE_SIZE)
    ) u_serializer (
        .clock      (i_clock),
        .reset      (i_reset),
        .load       (ser_load),
        .word       (ser_word),
        .send       (state == ST_SEND),
        .ready      (i_tx_ready),
        .valid      (o_tx_valid),
        .data       (o_tx_data),
        .last_accept(last_accept)
    );

endmodule

// File: tb/tb_debug_reg_dump.sv
// Directed bench for debug_reg_dump: models the register bank read port and
// the UART side, and compares the byte stream against the preloaded words.
module tb_debug_reg_dump;

`ifdef DEBUG_DUMP_PC_EN
    localparam int NBYTES   = 132;
    localparam int DONE_CYC = 230;
`else
    localparam int NBYTES   = 128;
    localparam int DONE_CYC = 225;
`endif
    localparam logic [31:0] PC_VALUE = 32'h0000_0040;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_rb_data;
    logic        i_tx_ready;
    logic        o_rb_read_enable;
    logic [4:0]  o_rb_read_addr;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;

    logic [31:0] regs [32];
    logic [7:0]  byteQ [$];
    logic [4:0]  addrQ [$];
    int          stallErr = 0;
    logic        prevStall = 1'b0;
    logic [7:0]  prevData = '0;
    int          cyc = 0;
    int          readyMode = 0;
    int          checkCount = 0;
    int          passCount = 0;

    debug_reg_dump dut (
        .i_clock         (clock),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_rb_data       (i_rb_data),
        .i_tx_ready      (i_tx_ready),
`ifdef DEBUG_DUMP_PC_EN
        .i_pc            (PC_VALUE),
`endif
        .o_rb_read_enable(o_rb_read_enable),
        .o_rb_read_addr  (o_rb_read_addr),
        .o_tx_valid      (o_tx_valid),
        .o_tx_data       (o_tx_data),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clock = ~clock;

    // Register bank: data appears the cycle after the read strobe, garbage otherwise.
    always @(posedge clock) begin
        if (o_rb_read_enable) i_rb_data <= regs[o_rb_read_addr];
        else                  i_rb_data <= 32'hBAD0_BAD0;
    end

    // UART-side monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (i_reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall && (!o_tx_valid || o_tx_data != prevData)) stallErr++;
            if (o_tx_valid && i_tx_ready) byteQ.push_back(o_tx_data);
            if (o_rb_read_enable) addrQ.push_back(o_rb_read_addr);
            prevStall = o_tx_valid && !i_tx_ready;
            prevData  = o_tx_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
        cyc++;
        i_tx_ready = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 0);
    endtask

    // Pulses start for the cycle that is sampled as cycle 0 of a dump.
    task automatic applyStimulus();
        byteQ.delete();
        addrQ.delete();
        cyc = 0;
        i_start = 1'b1;
        stepCycle();
        i_start = 1'b0;
    endtask

    task automatic waitDone(output int doneCyc);
        int busyErr = 0;
        int limit = cyc + 2000;
        while (!o_done && cyc < limit) begin
            if (!o_busy) busyErr++;
            stepCycle();
        end
        doneCyc = o_done ? cyc : -1;
        checkOutput("busy_during_dump", busyErr, 0);
        checkOutput("busy_in_done", o_busy, 1'b1);
    endtask

    task automatic compareStream(input string tag);
        int bad = 0;
        int addrBad = 0;
        logic [31:0] word;
        logic [7:0]  expByte;
        for (int i = 0; i < NBYTES; i++) begin
            word    = (i >= 128) ? PC_VALUE : regs[i / 4];
            expByte = 8'(word >> (8 * (3 - (i % 4))));
            if (i >= byteQ.size() || byteQ[i] != expByte) bad++;
        end
        for (int i = 0; i < addrQ.size(); i++) begin
            if (addrQ[i] != 5'(i)) addrBad++;
        end
        checkOutput({tag, "_byte_count"}, byteQ.size(), NBYTES);
        checkOutput({tag, "_byte_errors"}, bad, 0);
        checkOutput({tag, "_read_count"}, addrQ.size(), 32);
        checkOutput({tag, "_addr_order"}, addrBad, 0);
        checkOutput({tag, "_stall_stable"}, stallErr, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCyc;
        int done1;
        for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_tx_ready = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("reset_busy", o_busy, 1'b0);
        checkOutput("reset_done", o_done, 1'b0);
        checkOutput("reset_valid", o_tx_valid, 1'b0);
        checkOutput("reset_rd_en", o_rb_read_enable, 1'b0);
        checkOutput("reset_addr", o_rb_read_addr, 5'd0);
        i_reset = 1'b0;
        stepCycle();

        // Ready tied high: fixed latency and the full stream.
        $display("[TB] dump with ready high");
        applyStimulus();
        checkOutput("c1_rd_en", o_rb_read_enable, 1'b1);
        checkOutput("c1_addr", o_rb_read_addr, 5'd0);
        checkOutput("c1_busy", o_busy, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("c3_valid", o_tx_valid, 1'b1);
        checkOutput("c3_data", o_tx_data, 8'h10);
        waitDone(doneCyc);
        checkOutput("done_cycle", doneCyc, DONE_CYC);
        stepCycle();
        checkOutput("idle_after_done", o_busy, 1'b0);
        compareStream("ready_high");
        checkOutput("byte4", byteQ[4], 8'h10);
        checkOutput("byte7", byteQ[7], 8'h01);
        checkOutput("byte127", byteQ[127], 8'h1F);

        // Ready 1,0,0 pattern: same stream, stalled bytes stay stable.
        $display("[TB] dump with ready toggling");
        readyMode = 1;
        applyStimulus();
        waitDone(doneCyc);
        checkOutput("toggle_done_seen", doneCyc > DONE_CYC, 1'b1);
        stepCycle();
        compareStream("ready_toggle");
        readyMode = 0;

        // Reset while register 5 byte 2 is on the bus.
        $display("[TB] reset mid-dump");
        applyStimulus();
        while (!(byteQ.size() == 22 && o_tx_valid) && cyc < 500) stepCycle();
        checkOutput("mid_reached", byteQ.size(), 22);
        checkOutput("mid_addr", o_rb_read_addr, 5'd5);
        checkOutput("mid_data", o_tx_data, 8'h00);
        i_reset = 1'b1;
        stepCycle();
        checkOutput("mid_rst_busy", o_busy, 1'b0);
        checkOutput("mid_rst_valid", o_tx_valid, 1'b0);
        checkOutput("mid_rst_data", o_tx_data, 8'h00);
        checkOutput("mid_rst_addr", o_rb_read_addr, 5'd0);
        checkOutput("mid_rst_rd_en", o_rb_read_enable, 1'b0);
        i_reset = 1'b0;
        stepCycle();
        applyStimulus();
        waitDone(doneCyc);
        checkOutput("after_rst_done", doneCyc, DONE_CYC);
        stepCycle();
        compareStream("after_reset");

        // Start during SEND is ignored; start held across DONE restarts at once.
        $display("[TB] start during SEND and DONE");
        regs[0]  = 32'h0000_0000;
        regs[31] = 32'hDEAD_BEEF;
        applyStimulus();
        stepCycle();
        stepCycle();
        i_start = 1'b1;
        stepCycle();
        i_start = 1'b0;
        waitDone(done1);
        checkOutput("first_done", done1, DONE_CYC);
        checkOutput("first_bytes", byteQ.size(), NBYTES);
        i_start = 1'b1;
        stepCycle();
        checkOutput("restart_idle", o_busy, 1'b0);
        stepCycle();
        i_start = 1'b0;
        checkOutput("restart_req", o_rb_read_enable, 1'b1);
        byteQ.delete();
        addrQ.delete();
        waitDone(doneCyc);
        checkOutput("second_done", doneCyc, 2 * DONE_CYC + 1);
        stepCycle();
        compareStream("second_dump");
        checkOutput("first_b0", byteQ[0], 8'h00);
        checkOutput("first_b3", byteQ[3], 8'h00);
        checkOutput("last_b124", byteQ[124], 8'hDE);
        checkOutput("last_b125", byteQ[125], 8'hAD);
        checkOutput("last_b126", byteQ[126], 8'hBE);
        checkOutput("last_b127", byteQ[127], 8'hEF);
`ifdef DEBUG_DUMP_PC_EN
        checkOutput("pc_b131", byteQ[131], 8'h40);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
